// File: rtl/order_tx_pkg.sv
// Shared constants, types and FSM encoding for the order TX framer.
package order_tx_pkg;

  localparam int          FRAME_WORDS   = 15;
  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  IP_VER_IHL    = 8'h45;
  localparam logic [7:0]  IP_TOS        = 8'h00;
  localparam logic [7:0]  IP_PROTO_UDP  = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF   = 16'h4000;
  localparam logic [15:0] IP_TOTAL_LEN  = 16'd46;
  localparam logic [15:0] UDP_LEN       = 16'd26;
  localparam logic [15:0] UDP_CSUM      = 16'h0000;
  localparam logic [7:0]  SIDE_BUY      = 8'h42;
  localparam logic [7:0]  SIDE_SELL     = 8'h53;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CSUM = 2'd1,
    SEND = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] id;
    logic [31:0] price;
    logic [31:0] qty;
    logic        is_buy;
    logic [7:0]  mtype;
  } order_t;

  function automatic logic [7:0] side_byte(input logic is_buy);
    return is_buy ? SIDE_BUY : SIDE_SELL;
  endfunction

endpackage

// File: rtl/ipv4_csum.sv
// Ones-complement fold of a raw 16-bit-word sum into a final IPv4 header checksum.
module ipv4_csum (
  input  logic [19:0] raw_sum,
  output logic [15:0] csum
);

  logic [16:0] fold1;
  logic [15:0] fold2;

  // Two end-around carry folds are enough for a sum of ten 16-bit words.
  assign fold1 = {1'b0, raw_sum[15:0]} + {13'd0, raw_sum[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};
  assign csum  = ~fold2;

endmodule

// File: rtl/order_tx_framer.sv
// Serializes one order per handshake into a 60-byte Eth/IPv4/UDP frame on a
// 32-bit AXI-Stream (15 beats). Optional qty limiting: ORDER_TX_QTY_LIMIT_EN.
module order_tx_framer
  import order_tx_pkg::*;
#(
  parameter logic [47:0] DST_MAC  = 48'h01005E000001,
  parameter logic [47:0] SRC_MAC  = 48'h020000000001,
  parameter logic [31:0] SRC_IP   = 32'h0A000001,
  parameter logic [31:0] DST_IP   = 32'h0A000002,
  parameter logic [15:0] SRC_PORT = 16'h9C40,
  parameter logic [15:0] DST_PORT = 16'h7531,
  parameter logic [7:0]  TTL      = 8'd64,
  parameter logic [31:0] MAX_QTY  = 32'd1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_order_valid,
  output logic        s_order_ready,
  input  logic [31:0] s_order_id,
  input  logic [31:0] s_order_price,
  input  logic [31:0] s_order_qty,
  input  logic        s_order_is_buy,
  input  logic [7:0]  s_order_type,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [31:0] tx_seq,
  output logic        order_rejected
);

`ifdef ORDER_TX_QTY_LIMIT_EN
  localparam bit QTY_LIMIT_EN = 1'b1;
`else
  localparam bit QTY_LIMIT_EN = 1'b0;
`endif

  state_t      state, state_nxt;
  order_t      ord_q;
  logic [31:0] seq_q, tx_seq_q;
  logic [15:0] csum_q, csum_w;
  logic [19:0] raw_sum;
  logic [3:0]  idx_q;
  logic        run_q, rej_q;
  logic        hs, drop, beat, last_beat;
  logic [31:0] word;

  assign s_order_ready  = run_q && (state == IDLE);
  assign hs             = s_order_valid && s_order_ready;
  assign drop           = hs && QTY_LIMIT_EN && ((s_order_qty == 32'd0) || (s_order_qty > MAX_QTY));
  assign m_axis_tvalid  = (state == SEND);
  assign beat           = m_axis_tvalid && m_axis_tready;
  assign last_beat      = beat && (idx_q == 4'(FRAME_WORDS - 1));
  assign m_axis_tlast   = m_axis_tvalid && (idx_q == 4'(FRAME_WORDS - 1));
  assign m_axis_tdata   = m_axis_tvalid ? word : 32'd0;
  assign tx_seq         = tx_seq_q;
  assign order_rejected = rej_q;

  // Raw header sum; the ident word is the sequence number latched with the order.
  assign raw_sum = 20'({IP_VER_IHL, IP_TOS}) + 20'(IP_TOTAL_LEN) + 20'(seq_q[15:0])
                 + 20'(IP_FLAGS_DF) + 20'({TTL, IP_PROTO_UDP})
                 + 20'(SRC_IP[31:16]) + 20'(SRC_IP[15:0])
                 + 20'(DST_IP[31:16]) + 20'(DST_IP[15:0]);

  ipv4_csum u_csum (
    .raw_sum (raw_sum),
    .csum    (csum_w)
  );

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs && !drop) state_nxt = CSUM;
      CSUM:    state_nxt = SEND;
      SEND:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; run_q holds ready low for the reset cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      run_q <= 1'b0;
    end else begin
      state <= state_nxt;
      run_q <= 1'b1;
    end
  end

  // Order capture, checksum stage, beat index, sequence and reject pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ord_q    <= '0;
      seq_q    <= '0;
      csum_q   <= '0;
      idx_q    <= '0;
      tx_seq_q <= '0;
      rej_q    <= 1'b0;
    end else begin
      rej_q <= drop;
      if (hs) begin
        ord_q <= '{id: s_order_id, price: s_order_price, qty: s_order_qty,
                   is_buy: s_order_is_buy, mtype: s_order_type};
        seq_q <= tx_seq_q;
      end
      if (state == CSUM) begin
        csum_q <= csum_w;
        idx_q  <= '0;
      end else if (beat) begin
        idx_q <= idx_q + 4'd1;
      end
      if (last_beat) tx_seq_q <= seq_q + 32'd1;
    end
  end

  // Word map; everything comes from registers so data holds through stalls.
  always_comb begin
    word = 32'd0;
    case (idx_q)
      4'd0:  word = DST_MAC[47:16];
      4'd1:  word = {DST_MAC[15:0], SRC_MAC[47:32]};
      4'd2:  word = SRC_MAC[31:0];
      4'd3:  word = {ETH_TYPE_IPV4, IP_VER_IHL, IP_TOS};
      4'd4:  word = {IP_TOTAL_LEN, seq_q[15:0]};
      4'd5:  word = {IP_FLAGS_DF, TTL, IP_PROTO_UDP};
      4'd6:  word = {csum_q, SRC_IP[31:16]};
      4'd7:  word = {SRC_IP[15:0], DST_IP[31:16]};
      4'd8:  word = {DST_IP[15:0], SRC_PORT};
      4'd9:  word = {DST_PORT, UDP_LEN};
      4'd10: word = {UDP_CSUM, ord_q.mtype, side_byte(ord_q.is_buy)};
      4'd11: word = ord_q.id;
      4'd12: word = ord_q.price;
      4'd13: word = ord_q.qty;
      4'd14: word = seq_q;
      default: word = 32'd0;
    endcase
  end

endmodule
